// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and sync helpers shared by the
// VGA timing generator and its per-axis counters.
package vga_timing_pkg;

    localparam int VGA_H_DISPLAY = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_DISPLAY = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    localparam int VGA_H_TOTAL = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_TOTAL = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    localparam int VGA_H_SYNC_START = VGA_H_DISPLAY + VGA_H_FRONT;
    localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
    localparam int VGA_V_SYNC_START = VGA_V_DISPLAY + VGA_V_FRONT;
    localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

    localparam bit VGA_SYNC_POL = 1'b0;
    localparam int VGA_CNT_W    = 10;

    // Drive the active level inside the sync window, the idle level outside.
    function automatic logic sync_level(input logic in_win, input logic pol);
        return in_win ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Timing outputs and advance enable of the VGA sync generator; master is
// the generator side, slave is the consumer (pixel/player logic).
interface vga_sync_gen_if
    import vga_timing_pkg::*;
#(
    parameter int W = VGA_CNT_W
);
    logic         ena;
    logic [W-1:0] hpos;
    logic [W-1:0] vpos;
    logic         display_on;
    logic         hsync;
    logic         vsync;
    logic         line_start;
    logic         frame_start;
    logic [7:0]   frame_cnt;

    modport master (
        input  ena,
        output hpos, vpos, display_on, hsync, vsync,
               line_start, frame_start, frame_cnt
    );

    modport slave (
        output ena,
        input  hpos, vpos, display_on, hsync, vsync,
               line_start, frame_start, frame_cnt
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter with registered display-active
// and sync flags decoded from the next position so they align with pos.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL      = VGA_H_TOTAL,
    parameter int DISPLAY    = VGA_H_DISPLAY,
    parameter int SYNC_START = VGA_H_SYNC_START,
    parameter int SYNC_END   = VGA_H_SYNC_END,
    parameter bit POL        = VGA_SYNC_POL,
    parameter int W          = VGA_CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         step,
    output logic         wrap_out,
    output logic [W-1:0] pos,
    output logic         active,
    output logic         sync
);
    localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
    localparam logic [W-1:0] DISP_LT = W'(DISPLAY);
    localparam logic [W-1:0] SYNC_LO = W'(SYNC_START);
    localparam logic [W-1:0] SYNC_HI = W'(SYNC_END);

    logic [W-1:0] pos_d, pos_q;
    logic         active_d, active_q;
    logic         sync_d, sync_q;

    // Wrap is decoded from the current position so the next axis can step in
    // the same edge that returns this one to zero.
    assign wrap_out = (pos_q == LAST);

    always_comb begin
        pos_d = pos_q;
        if (step) pos_d = wrap_out ? '0 : pos_q + 1'b1;
        active_d = (pos_d < DISP_LT);
        sync_d   = sync_level((pos_d >= SYNC_LO) && (pos_d <= SYNC_HI), POL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos_q    <= LAST;
            active_q <= 1'b0;
            sync_q   <= ~POL;
        end else begin
            pos_q    <= pos_d;
            active_q <= active_d;
            sync_q   <= sync_d;
        end
    end

    assign pos    = pos_q;
    assign active = active_q;
    assign sync   = sync_q;
endmodule

// File: rtl/vga_sync_gen.sv
// Free-running VGA timing generator: two axis counters plus line/frame
// strobes and an 8-bit frame counter, all registered and mutually aligned.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY = VGA_H_DISPLAY,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_DISPLAY = VGA_V_DISPLAY,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK,
    parameter bit SYNC_POL  = VGA_SYNC_POL,
    parameter int CNT_W     = VGA_CNT_W
) (
    input logic           clk,
    input logic           rst_n,
    vga_sync_gen_if.master vif
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    logic             h_wrap, v_wrap, v_step;
    logic             h_active, v_active, h_sync, v_sync;
    logic [CNT_W-1:0] h_pos, v_pos;

    logic       line_start_d, line_start_q;
    logic       frame_start_d, frame_start_q;
    logic [7:0] frame_cnt_d, frame_cnt_q;

    assign v_step = h_wrap & vif.ena;

    vga_axis_counter #(
        .TOTAL(H_TOTAL), .DISPLAY(H_DISPLAY),
        .SYNC_START(H_DISPLAY + H_FRONT), .SYNC_END(H_DISPLAY + H_FRONT + H_SYNC - 1),
        .POL(SYNC_POL), .W(CNT_W)
    ) u_h (
        .clk(clk), .rst_n(rst_n), .step(vif.ena), .wrap_out(h_wrap),
        .pos(h_pos), .active(h_active), .sync(h_sync)
    );

    vga_axis_counter #(
        .TOTAL(V_TOTAL), .DISPLAY(V_DISPLAY),
        .SYNC_START(V_DISPLAY + V_FRONT), .SYNC_END(V_DISPLAY + V_FRONT + V_SYNC - 1),
        .POL(SYNC_POL), .W(CNT_W)
    ) u_v (
        .clk(clk), .rst_n(rst_n), .step(v_step), .wrap_out(v_wrap),
        .pos(v_pos), .active(v_active), .sync(v_sync)
    );

    // Strobes fire on the advance that lands on column 0 / origin, so they
    // drop to 0 whenever the edge is frozen.
    always_comb begin
        line_start_d  = vif.ena & h_wrap;
        frame_start_d = line_start_d & v_wrap;
        frame_cnt_d   = frame_cnt_q + {7'd0, frame_start_d};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= 8'hFF;
        end else begin
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign vif.hpos        = h_pos;
    assign vif.vpos        = v_pos;
    assign vif.display_on  = h_active & v_active;
    assign vif.hsync       = h_sync;
    assign vif.vsync       = v_sync;
    assign vif.line_start  = line_start_q;
    assign vif.frame_start = frame_start_q;
    assign vif.frame_cnt   = frame_cnt_q;
endmodule
